irrig_phase_sequencer: RTL and testbench

- Parametrised successor to the fixed two-value timer chain: counter, value register, timer control and process FSM.
- Sequences NPH irrigation/process phases. Each phase has its own programmable duration, loaded from a flat duration bus.
- Adds pause (Hold), abort, and continuous-repeat modes.
- Sits between the init/operation FSMs (which raise Start/Hold/Abort) and the actuator outputs; drives one one-hot enable per phase.

---
 rtl/irrig_phase_sequencer.sv | 122 ++++++++++++
 tb/tb_irrig_phase_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/irrig_phase_sequencer.sv
// Irrigation phase sequencer: steps through NPH timed phases with hold, abort and repeat.
// Each phase duration is loaded from the flat Dur bus when that phase starts.
module irrig_phase_sequencer #(
  parameter int unsigned NPH = 4,
  parameter int unsigned W   = 8,
  localparam int unsigned IW = $clog2(NPH)
) (
  input  logic             Ck,
  input  logic             Clr,
  input  logic             Start,
  input  logic             Hold,
  input  logic             Abort,
  input  logic             Repeat,
  input  logic [NPH*W-1:0] Dur,
  output logic [NPH-1:0]   Phase_en,
  output logic [IW-1:0]    Phase_idx,
  output logic [W-1:0]     Remaining,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NPH - 1);

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [IW-1:0]  idx_nxt;
  logic [W-1:0]   rem_nxt;
  logic           done_nxt;
  logic [NPH-1:0] en_nxt;
  logic           busy_nxt;

  // Zero-length phases still occupy one cycle so no phase is ever skipped.
  function automatic logic [W-1:0] eff_dur(input logic [NPH*W-1:0] dv,
                                           input logic [IW-1:0]    k);
    logic [W-1:0] d;
    d = dv[int'(k)*W +: W];
    return (d == '0) ? W'(1) : d;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = Phase_idx;
    rem_nxt   = Remaining;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (Start && !Abort) begin
          idx_nxt   = '0;
          rem_nxt   = eff_dur(Dur, '0);
          state_nxt = Hold ? PAUSE : RUN;
        end
      end
      RUN: begin
        if (Abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          rem_nxt   = '0;
        end else if (Hold) begin
          state_nxt = PAUSE;
        end else if (Remaining > W'(1)) begin
          rem_nxt = Remaining - W'(1);
        end else if (Phase_idx != LAST_IDX) begin
          idx_nxt = Phase_idx + IW'(1);
          rem_nxt = eff_dur(Dur, idx_nxt);
        end else begin
          // Final phase complete: pulse Done, then wrap or stop.
          done_nxt = 1'b1;
          idx_nxt  = '0;
          if (Repeat) begin
            rem_nxt = eff_dur(Dur, '0);
          end else begin
            state_nxt = IDLE;
            rem_nxt   = '0;
          end
        end
      end
      PAUSE: begin
        if (Abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          rem_nxt   = '0;
        end else if (!Hold) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        rem_nxt   = '0;
      end
    endcase

    en_nxt   = (state_nxt == RUN) ? (NPH'(1) << idx_nxt) : '0;
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge Ck) begin
    if (Clr) begin
      state     <= IDLE;
      Phase_idx <= '0;
      Remaining <= '0;
      Done      <= 1'b0;
      Phase_en  <= '0;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      Phase_idx <= idx_nxt;
      Remaining <= rem_nxt;
      Done      <= done_nxt;
      Phase_en  <= en_nxt;
      Busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_irrig_phase_sequencer.sv
// Directed bench for irrig_phase_sequencer: per-cycle vector table plus a long-duration sequence.
module tb_irrig_phase_sequencer;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] C = 5'b10000;
  localparam logic [4:0] S = 5'b01000;
  localparam logic [4:0] H = 5'b00100;
  localparam logic [4:0] A = 5'b00010;
  localparam logic [4:0] R = 5'b00001;

  localparam logic [31:0] D1  = 32'h04010203;  // phase0..3 = 3,2,1,4
  localparam logic [31:0] D5  = 32'h00020000;  // phase0..3 = 0,0,2,0
  localparam logic [31:0] D5B = 32'h00090000;  // phase2 changed to 9

  // Row: outputs expected in this cycle, then inputs driven during this cycle.
  typedef struct {
    logic [4:0]  in;
    logic [31:0] dur;
    logic [3:0]  en;
    logic [1:0]  idx;
    logic [7:0]  rem;
    logic        busy;
    logic        done;
  } vec_t;

  logic        Ck;
  logic        Clr;
  logic        Start;
  logic        Hold;
  logic        Abort;
  logic        Repeat;
  logic [31:0] Dur;
  logic [3:0]  Phase_en;
  logic [1:0]  Phase_idx;
  logic [7:0]  Remaining;
  logic        Busy;
  logic        Done;

  int tests;
  int fails;
  vec_t tbl[$];

  irrig_phase_sequencer #(.NPH(4), .W(8)) dut (
    .Ck        (Ck),
    .Clr       (Clr),
    .Start     (Start),
    .Hold      (Hold),
    .Abort     (Abort),
    .Repeat    (Repeat),
    .Dur       (Dur),
    .Phase_en  (Phase_en),
    .Phase_idx (Phase_idx),
    .Remaining (Remaining),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  function automatic vec_t r(input logic [4:0] in, input logic [31:0] dur,
                             input logic [3:0] en, input int idx, input int rem,
                             input logic busy, input logic done);
    vec_t v;
    v.in   = in;
    v.dur  = dur;
    v.en   = en;
    v.idx  = 2'(idx);
    v.rem  = 8'(rem);
    v.busy = busy;
    v.done = done;
    return v;
  endfunction

  task automatic step();
    @(posedge Ck);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] en, input logic [1:0] idx,
                     input logic [7:0] rem, input logic busy, input logic done);
    tests++;
    if (Phase_en !== en || Phase_idx !== idx || Remaining !== rem ||
        Busy !== busy || Done !== done) begin
      fails++;
      $display("FAIL %s: got en=%b idx=%0d rem=%0d busy=%b done=%b, want en=%b idx=%0d rem=%0d busy=%b done=%b",
               name, Phase_en, Phase_idx, Remaining, Busy, Done, en, idx, rem, busy, done);
    end
  endtask

  task automatic drive(input logic [4:0] in, input logic [31:0] dur);
    {Clr, Start, Hold, Abort, Repeat} = in;
    Dur = dur;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drive(C, D1);

    // Reset state, then basic sequence.
    tbl.push_back(r(N,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(S,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 3, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 2, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 1, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0010, 1, 2, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0010, 1, 1, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0100, 2, 1, 1, 0));
    for (int k = 4; k >= 1; k--) tbl.push_back(r(N, D1, 4'b1000, 3, k, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(r(N,   D1, 4'b0000, 0, 0, 0, 0));
    // Pause during phase 1.
    tbl.push_back(r(S,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 3, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 2, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 1, 1, 0));
    tbl.push_back(r(H,   D1, 4'b0010, 1, 2, 1, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(r(H, D1, 4'b0000, 1, 2, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0000, 1, 2, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0010, 1, 2, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0010, 1, 1, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0100, 2, 1, 1, 0));
    for (int k = 4; k >= 1; k--) tbl.push_back(r(N, D1, 4'b1000, 3, k, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0000, 0, 0, 0, 1));
    // Abort mid-sequence, restart, abort again.
    tbl.push_back(r(S,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 3, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 2, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 1, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0010, 1, 2, 1, 0));
    tbl.push_back(r(A,   D1, 4'b0010, 1, 1, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(S,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 3, 1, 0));
    tbl.push_back(r(A,   D1, 4'b0001, 0, 2, 1, 0));
    // Repeat mode: back-to-back rounds with Done overlapping phase 0.
    tbl.push_back(r(S|R, D1, 4'b0000, 0, 0, 0, 0));
    for (int rnd = 0; rnd < 2; rnd++) begin
      tbl.push_back(r(R, D1, 4'b0001, 0, 3, 1, logic'(rnd == 1)));
      tbl.push_back(r(R, D1, 4'b0001, 0, 2, 1, 0));
      tbl.push_back(r(R, D1, 4'b0001, 0, 1, 1, 0));
      tbl.push_back(r(R, D1, 4'b0010, 1, 2, 1, 0));
      tbl.push_back(r(R, D1, 4'b0010, 1, 1, 1, 0));
      tbl.push_back(r(R, D1, 4'b0100, 2, 1, 1, 0));
      for (int k = 4; k >= 1; k--) tbl.push_back(r(R, D1, 4'b1000, 3, k, 1, 0));
    end
    tbl.push_back(r(A|R, D1, 4'b0001, 0, 3, 1, 1));
    // Zero durations and a Dur change mid-phase.
    tbl.push_back(r(S,   D5,  4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(N,   D5,  4'b0001, 0, 1, 1, 0));
    tbl.push_back(r(N,   D5,  4'b0010, 1, 1, 1, 0));
    tbl.push_back(r(N,   D5B, 4'b0100, 2, 2, 1, 0));
    tbl.push_back(r(N,   D5B, 4'b0100, 2, 1, 1, 0));
    tbl.push_back(r(N,   D5B, 4'b1000, 3, 1, 1, 0));
    tbl.push_back(r(N,   D1,  4'b0000, 0, 0, 0, 1));
    // Clr beats Start; Abort beats Start in IDLE; Start with Hold enters PAUSE.
    tbl.push_back(r(S,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 3, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0001, 0, 2, 1, 0));
    tbl.push_back(r(C|S, D1, 4'b0001, 0, 1, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(S|A, D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(C|S, D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(S|H, D1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(r(N,   D1, 4'b0000, 0, 3, 1, 0));
    tbl.push_back(r(A,   D1, 4'b0001, 0, 3, 1, 0));
    tbl.push_back(r(N,   D1, 4'b0000, 0, 0, 0, 0));

    step();
    step();
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("row%0d", i), tbl[i].en, tbl[i].idx, tbl[i].rem, tbl[i].busy, tbl[i].done);
      drive(tbl[i].in, tbl[i].dur);
      step();
    end

    // Maximum duration 255 counts down without wrapping.
    drive(S, 32'h010101FF);
    step();
    drive(N, 32'h010101FF);
    chk("max_load", 4'b0001, 2'd0, 8'd255, 1'b1, 1'b0);
    repeat (254) step();
    chk("max_last", 4'b0001, 2'd0, 8'd1, 1'b1, 1'b0);
    step();
    chk("max_next", 4'b0010, 2'd1, 8'd1, 1'b1, 1'b0);
    step();
    step();
    chk("max_ph3", 4'b1000, 2'd3, 8'd1, 1'b1, 1'b0);
    // Hold on the final cycle defers completion.
    drive(H, 32'h010101FF);
    step();
    chk("hold_last", 4'b0000, 2'd3, 8'd1, 1'b1, 1'b0);
    drive(N, 32'h010101FF);
    step();
    chk("resume_last", 4'b1000, 2'd3, 8'd1, 1'b1, 1'b0);
    step();
    chk("done_after_hold", 4'b0000, 2'd0, 8'd0, 1'b0, 1'b1);
    step();
    chk("done_one_cycle", 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
